// File: rtl/vote_link_pkg.sv
// Shared types and link codes for the central-side vote peer.
package vote_link_pkg;

  // Controller states; every state other than IDLE waits on one link event.
  typedef enum logic [2:0] {
    IDLE,
    RX_REQ,
    TX_WAIT_CTR,
    TX_DRIVE,
    TX_REL,
    DONE_WAIT
  } state_t;

  // The first word of a session is the vote; later words echo our last reply.
  typedef enum logic {
    PH_VOTE,
    PH_ECHO
  } phase_t;

  localparam logic [3:0] ACK = 4'b0110;
  localparam logic [3:0] NAK = 4'b1001;

  // Reply word chosen by the controller's accept level.
  function automatic logic [3:0] reply_for(input logic accept);
    return accept ? ACK : NAK;
  endfunction

endpackage

// File: rtl/vote_peer_if.sv
// Four-wire rts/rtr/cts/ctr link between the voting station and the central peer.
// master = central peer (this design), slave = voting station.
interface vote_peer_if;
  logic       rtr;    // peer asks station for a word
  logic       rts;    // peer presents a reply on v_in
  logic [3:0] v_in;   // reply word to station
  logic       cts;    // station word valid on v_out
  logic       ctr;    // station ready to take a reply
  logic [3:0] v_out;  // vote/echo word from station

  modport master (output rtr, rts, v_in, input cts, ctr, v_out);
  modport slave  (input rtr, rts, v_in, output cts, ctr, v_out);
endinterface

// File: rtl/vote_tally_sat.sv
// Saturating up-counter: adds one per enabled cycle, sticks at all-ones.
module vote_tally_sat #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register; holds at its maximum instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/vote_peer.sv
// Central-side partner of the voting station. Pulls a vote word over the
// rtr/cts leg, answers ACK/NAK over the rts/ctr leg until the station echoes
// ACK, then commits the vote into saturating green/red tallies.
// Optional watchdog: define VOTE_PEER_TIMEOUT_EN to abort any wait state
// that lasts TIMEOUT_CYCLES cycles.
module vote_peer
  import vote_link_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             poll,
  input  logic             accept,
  vote_peer_if.master      link,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] red_cnt,
  output logic             sess_done,
  output logic             busy,
  output logic             err
);

  state_t     state, state_next;
  phase_t     phase, phase_next;
  logic [3:0] vword, vword_next;
  logic [3:0] reply, reply_next;
  logic [3:0] v_in_next;
  logic       err_next;
  logic       done_next;
  logic       green_inc;
  logic       red_inc;
  logic       tmo_hit;

`ifdef VOTE_PEER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr;

  // Per-state watchdog; restarts whenever the state changes and idles in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr <= '0;
    end else if ((state == IDLE) || (state_next != state)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  assign tmo_hit = (state != IDLE) && (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog in this build: wait states hold indefinitely.
  assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Next-state and next-output decode; each wait state reacts only to its own event.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    phase_next = phase;
    vword_next = vword;
    reply_next = reply;
    v_in_next  = link.v_in;
    err_next   = 1'b0;
    done_next  = 1'b0;
    green_inc  = 1'b0;
    red_inc    = 1'b0;

    unique case (state)
      IDLE: begin
        if (poll) begin
          phase_next = PH_VOTE;
          state_next = RX_REQ;
        end
      end
      RX_REQ: begin
        if (link.cts) begin
          if (link.v_out == ACK) begin
            // An ACK word closes the session whichever phase we are in.
            if (phase == PH_VOTE) vword_next = link.v_out;
            state_next = DONE_WAIT;
          end else if (phase == PH_VOTE) begin
            vword_next = link.v_out;
            reply_next = reply_for(accept);
            state_next = TX_WAIT_CTR;
          end else if (link.v_out == reply) begin
            reply_next = reply_for(accept);
            state_next = TX_WAIT_CTR;
          end else begin
            // Corrupted echo: flag it and force the station to retry.
            err_next   = 1'b1;
            reply_next = NAK;
            state_next = TX_WAIT_CTR;
          end
        end
      end
      TX_WAIT_CTR: begin
        if (link.ctr) begin
          v_in_next  = reply;
          state_next = TX_DRIVE;
        end
      end
      TX_DRIVE: begin
        if (!link.ctr) begin
          phase_next = PH_ECHO;
          state_next = TX_REL;
        end
      end
      TX_REL: begin
        if (!link.cts) state_next = RX_REQ;
      end
      DONE_WAIT: begin
        if (!link.cts) begin
          green_inc  = vword[1];
          red_inc    = vword[2];
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Watchdog abort only when the awaited event did not arrive this cycle.
    if (tmo_hit && (state_next == state)) begin
      err_next   = 1'b1;
      state_next = IDLE;
    end
  end

  // State and registered outputs; rtr/rts/busy are decoded from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= PH_VOTE;
      vword     <= '0;
      reply     <= '0;
      link.rtr  <= 1'b0;
      link.rts  <= 1'b0;
      link.v_in <= '0;
      sess_done <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= state_next;
      phase     <= phase_next;
      vword     <= vword_next;
      reply     <= reply_next;
      link.rtr  <= (state_next == RX_REQ);
      link.rts  <= (state_next == TX_DRIVE);
      link.v_in <= v_in_next;
      sess_done <= done_next;
      busy      <= (state_next != IDLE);
      err       <= err_next;
    end
  end

  vote_tally_sat #(.W(CNT_W)) u_green (
    .clock (clock),
    .reset (reset),
    .inc   (green_inc),
    .count (green_cnt)
  );

  vote_tally_sat #(.W(CNT_W)) u_red (
    .clock (clock),
    .reset (reset),
    .inc   (red_inc),
    .count (red_cnt)
  );

endmodule

// File: tb/tb_vote_peer.sv
// Bench for vote_peer: plays the voting station, predicts replies and
// tallies at transaction level, and compares against the design.
module tb_vote_peer;

  localparam int         CNT_W = 2;
  localparam int         TMO   = 40;
  localparam int         MAXC  = (1 << CNT_W) - 1;
  localparam logic [3:0] ACK_W = 4'b0110;
  localparam logic [3:0] NAK_W = 4'b1001;

  logic             clock = 1'b0;
  logic             reset;
  logic             poll;
  logic             accept;
  logic [CNT_W-1:0] green_cnt;
  logic [CNT_W-1:0] red_cnt;
  logic             sess_done;
  logic             busy;
  logic             err;

  vote_peer_if link ();

  vote_peer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .poll      (poll),
    .accept    (accept),
    .link      (link),
    .green_cnt (green_cnt),
    .red_cnt   (red_cnt),
    .sess_done (sess_done),
    .busy      (busy),
    .err       (err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int g_ref    = 0;
  int r_ref    = 0;

  bit scripted;
  bit s_acc[8];
  bit s_bad[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return link.rtr;
      1:       return link.rts;
      2:       return sess_done;
      default: return err;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input int budget,
                          input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sig(which) === val) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic recover();
    reset      = 1'b1;
    poll       = 1'b0;
    accept     = 1'b0;
    link.cts   = 1'b0;
    link.ctr   = 1'b0;
    link.v_out = '0;
    tick();
    reset = 1'b0;
    g_ref = 0;
    r_ref = 0;
    tick();
  endtask

  task automatic set_script(input logic [7:0] acc, input logic [7:0] bad);
    scripted = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_acc[i] = acc[i];
      s_bad[i] = bad[i];
    end
  endtask

  // One full station session; expectations come from the link rules alone.
  task automatic run_session(input logic [3:0] first, input string tag);
    logic [3:0] word, last, vw, exp_reply;
    bit         vote_ph, exp_err, ok, acc, bad;
    int         rnd;
    vote_ph = 1'b1;
    word    = first;
    last    = '0;
    vw      = '0;
    rnd     = 0;

    poll = 1'b1;
    tick();
    check({tag, "_rtr_rise"}, link.rtr, 1);
    check({tag, "_busy"}, busy, 1);
    poll = 1'b0;

    forever begin
      if (scripted) acc = (rnd < 8) ? s_acc[rnd] : 1'b1;
      else          acc = (rnd >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
      accept     = acc;
      link.v_out = word;
      link.cts   = 1'b1;
      wait_sig(0, 1'b0, 50, {tag, "_rtr_fall"}, ok);
      if (!ok) begin recover(); return; end

      if (word == ACK_W) begin
        if (vote_ph) vw = word;
        check({tag, "_ack_err"}, err, 0);
        check({tag, "_ack_rts"}, link.rts, 0);
        repeat ($urandom_range(0, 2)) tick();
        link.cts = 1'b0;
        wait_sig(2, 1'b1, 20, {tag, "_done"}, ok);
        if (!ok) begin recover(); return; end
        g_ref = (g_ref + int'(vw[1]) > MAXC) ? MAXC : g_ref + int'(vw[1]);
        r_ref = (r_ref + int'(vw[2]) > MAXC) ? MAXC : r_ref + int'(vw[2]);
        check({tag, "_green"}, green_cnt, g_ref);
        check({tag, "_red"}, red_cnt, r_ref);
        check({tag, "_idle"}, busy, 0);
        tick();
        check({tag, "_done_pulse"}, sess_done, 0);
        return;
      end

      if (vote_ph) begin
        vw        = word;
        exp_err   = 1'b0;
        exp_reply = acc ? ACK_W : NAK_W;
      end else if (word == last) begin
        exp_err   = 1'b0;
        exp_reply = acc ? ACK_W : NAK_W;
      end else begin
        exp_err   = 1'b1;
        exp_reply = NAK_W;
      end
      check({tag, "_err"}, err, exp_err);
      tick();
      check({tag, "_err_pulse"}, err, 0);

      if ($urandom_range(0, 1) != 0) link.cts = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      link.ctr = 1'b1;
      wait_sig(1, 1'b1, 20, {tag, "_rts_rise"}, ok);
      if (!ok) begin recover(); return; end
      check({tag, "_v_in"}, link.v_in, exp_reply);
      repeat ($urandom_range(0, 2)) tick();
      check({tag, "_v_in_hold"}, {link.rts, link.v_in}, {1'b1, exp_reply});
      link.ctr = 1'b0;
      wait_sig(1, 1'b0, 20, {tag, "_rts_fall"}, ok);
      if (!ok) begin recover(); return; end
      link.cts = 1'b0;
      wait_sig(0, 1'b1, 20, {tag, "_rtr_again"}, ok);
      if (!ok) begin recover(); return; end

      last    = exp_reply;
      vote_ph = 1'b0;
      rnd++;
      if (scripted) bad = (rnd < 8) ? s_bad[rnd] : 1'b0;
      else          bad = (rnd < 4) && ($urandom_range(0, 3) == 0);
      if (!bad)          word = last;
      else if (scripted) word = last ^ 4'b1010;
      else               word = 4'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int cyc;
    reset      = 1'b1;
    poll       = 1'b0;
    accept     = 1'b0;
    link.cts   = 1'b0;
    link.ctr   = 1'b0;
    link.v_out = '0;
    #12;
    check("rst_outputs",
          {link.rtr, link.rts, link.v_in, green_cnt, red_cnt, sess_done, busy, err}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Accepted green vote.
    set_script(8'hFF, 8'h00);
    run_session(4'b0010, "green_ack");

    // First word is ACK: no reply leg, both tallies bump.
    recover();
    run_session(4'b0110, "ack_first");

    // NAK then ACK on a red vote.
    recover();
    set_script(8'b1111_1110, 8'h00);
    run_session(4'b0100, "red_nak");

    // Corrupted echo after NAK.
    recover();
    set_script(8'b1111_1110, 8'b0000_0010);
    run_session(4'b0010, "bad_echo");

    // Saturation of a 2-bit tally.
    recover();
    set_script(8'hFF, 8'h00);
    for (int i = 0; i < 4; i++) run_session(4'b0010, "sat");

    // Asynchronous reset while the reply is being driven.
    poll = 1'b1;
    tick();
    poll       = 1'b0;
    accept     = 1'b1;
    link.v_out = 4'b0010;
    link.cts   = 1'b1;
    wait_sig(0, 1'b0, 20, "rst_mid_rtr", ok);
    link.ctr = 1'b1;
    wait_sig(1, 1'b1, 20, "rst_mid_rts", ok);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_outputs",
          {link.rtr, link.rts, link.v_in, green_cnt, red_cnt, busy}, 0);
    link.ctr = 1'b0;
    link.cts = 1'b0;
    tick();
    reset = 1'b0;
    g_ref = 0;
    r_ref = 0;
    tick();

    // Random sessions.
    scripted = 1'b0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_session(4'($urandom), "rand");
    end

`ifdef VOTE_PEER_TIMEOUT_EN
    // Station never answers: watchdog abort out of RX_REQ.
    poll = 1'b1;
    tick();
    poll = 1'b0;
    check("tmo_rtr", link.rtr, 1);
    cyc = 0;
    while (!err && cyc < TMO + 10) begin
      tick();
      cyc++;
    end
    check("tmo_cycles", cyc, TMO);
    check("tmo_idle", {busy, link.rtr}, 0);
    check("tmo_no_commit", {green_cnt, red_cnt}, {CNT_W'(g_ref), CNT_W'(r_ref)});
`else
    cyc = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
